// File: rtl/demux_rr_sched_pkg.sv
// Shared definitions for the round-robin demux scheduler: FSM encodings and default sizes.
package demux_sched_pkg;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_NUM_OUT = 4;
    localparam int DEF_SEL_W   = 2;

    // Encoding 2'd3 is unused; the FSM treats it as a fault and falls back to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_SEND = 2'd2
    } state_t;

endpackage

// File: rtl/demux_rr_sched_if.sv
// Producer/consumer bus for the round-robin demux scheduler.
interface demux_rr_sched_if #(
    parameter int WIDTH   = 8,
    parameter int NUM_OUT = 4,
    parameter int SEL_W   = 2
);
    logic [WIDTH-1:0]   din;
    logic               din_valid;
    logic               din_ready;
    logic [NUM_OUT-1:0] en_mask;
    logic [NUM_OUT-1:0] dout_ready;
    logic [WIDTH-1:0]   dout;
    logic [NUM_OUT-1:0] dout_valid;
    logic [SEL_W-1:0]   sel;
    logic               busy;

    modport slave (
        input  din, din_valid, en_mask, dout_ready,
        output din_ready, dout, dout_valid, sel, busy
    );

    modport master (
        output din, din_valid, en_mask, dout_ready,
        input  din_ready, dout, dout_valid, sel, busy
    );
endinterface

// File: rtl/demux_rr_sched_rr_pick.sv
// Rotating first-one finder: lowest set bit of req at or after start, wrapping modulo NUM_OUT.
module rr_pick #(
    parameter int NUM_OUT = 4,
    parameter int SEL_W   = 2
) (
    input  logic [NUM_OUT-1:0] req,
    input  logic [SEL_W-1:0]   start,
    output logic [SEL_W-1:0]   idx,
    output logic               found
);
    logic [SEL_W-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest hit is written last and wins.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = NUM_OUT - 1; i >= 0; i--) begin
            cand = start + SEL_W'(i);
            if (req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/demux_rr_sched.sv
// Round-robin 1:N demux scheduler: buffers one word, picks an enabled output, holds it until taken.
// Optional macro DEMUX_RR_SCHED_SKIP_EN prefers enabled outputs that are already ready.
module demux_rr_sched
    import demux_sched_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NUM_OUT = DEF_NUM_OUT,
    parameter int SEL_W   = DEF_SEL_W
) (
    input  logic              clk,
    input  logic              rst,
    demux_rr_sched_if.slave   bus
);
    state_t           state;
    logic [WIDTH-1:0] word_buf;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] pick_idx;
    logic             pick_found;

`ifdef DEMUX_RR_SCHED_SKIP_EN
    logic [SEL_W-1:0] en_idx, rdy_idx;
    logic             en_found, rdy_found;

    rr_pick #(.NUM_OUT(NUM_OUT), .SEL_W(SEL_W)) u_pick_en (
        .req(bus.en_mask), .start(ptr), .idx(en_idx), .found(en_found)
    );
    rr_pick #(.NUM_OUT(NUM_OUT), .SEL_W(SEL_W)) u_pick_rdy (
        .req(bus.en_mask & bus.dout_ready), .start(ptr), .idx(rdy_idx), .found(rdy_found)
    );

    assign pick_idx   = rdy_found ? rdy_idx : en_idx;
    assign pick_found = en_found;
`else
    rr_pick #(.NUM_OUT(NUM_OUT), .SEL_W(SEL_W)) u_pick (
        .req(bus.en_mask), .start(ptr), .idx(pick_idx), .found(pick_found)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            ptr            <= '0;
            bus.sel        <= '0;
            bus.dout       <= '0;
            bus.dout_valid <= '0;
            bus.din_ready  <= 1'b1;
            bus.busy       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.din_valid && bus.din_ready) begin
                        word_buf      <= bus.din;
                        bus.din_ready <= 1'b0;
                        bus.busy      <= 1'b1;
                        state         <= ST_ARB;
                    end
                end
                ST_ARB: begin
                    // With nothing enabled the word simply waits here.
                    if (pick_found) begin
                        bus.sel        <= pick_idx;
                        bus.dout       <= word_buf;
                        bus.dout_valid <= NUM_OUT'(1) << pick_idx;
                        state          <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (bus.dout_ready[bus.sel]) begin
                        ptr            <= bus.sel + SEL_W'(1);
                        bus.dout_valid <= '0;
                        bus.din_ready  <= 1'b1;
                        bus.busy       <= 1'b0;
                        state          <= ST_IDLE;
                    end
                end
                default: begin
                    bus.dout_valid <= '0;
                    bus.din_ready  <= 1'b1;
                    bus.busy       <= 1'b0;
                    state          <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_demux_rr_sched.sv
// Randomized and directed bench for demux_rr_sched against a transaction-level reference model.
module tb_demux_rr_sched;
    localparam int WIDTH   = 8;
    localparam int NUM_OUT = 4;
    localparam int SEL_W   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    demux_rr_sched_if #(.WIDTH(WIDTH), .NUM_OUT(NUM_OUT), .SEL_W(SEL_W)) bus ();

    demux_rr_sched #(.WIDTH(WIDTH), .NUM_OUT(NUM_OUT), .SEL_W(SEL_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one pending word, its target once chosen, and the rotation start.
    bit             m_pend = 1'b0;
    int             m_tgt  = -1;
    int             m_ptr  = 0;
    int             m_sel  = 0;
    logic [WIDTH-1:0] m_word = '0;
    logic [WIDTH-1:0] m_dout = '0;

    function automatic int model_pick(input logic [NUM_OUT-1:0] en,
                                      input logic [NUM_OUT-1:0] rdy, input int p);
`ifdef DEMUX_RR_SCHED_SKIP_EN
        for (int off = 0; off < NUM_OUT; off++)
            if (en[(p + off) % NUM_OUT] && rdy[(p + off) % NUM_OUT]) return (p + off) % NUM_OUT;
`endif
        for (int off = 0; off < NUM_OUT; off++)
            if (en[(p + off) % NUM_OUT]) return (p + off) % NUM_OUT;
        return -1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_pend <= 1'b0; m_tgt <= -1; m_ptr <= 0; m_sel <= 0; m_dout <= '0;
        end else if (!m_pend) begin
            if (bus.din_valid) begin
                m_pend <= 1'b1;
                m_word <= bus.din;
            end
        end else if (m_tgt < 0) begin
            if (model_pick(bus.en_mask, bus.dout_ready, m_ptr) >= 0) begin
                m_tgt  <= model_pick(bus.en_mask, bus.dout_ready, m_ptr);
                m_sel  <= model_pick(bus.en_mask, bus.dout_ready, m_ptr);
                m_dout <= m_word;
            end
        end else if (bus.dout_ready[m_tgt]) begin
            m_ptr  <= (m_tgt + 1) % NUM_OUT;
            m_tgt  <= -1;
            m_pend <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_dout_valid", int'(bus.dout_valid), (m_tgt >= 0) ? (1 << m_tgt) : 0);
            chk("cyc_sel", int'(bus.sel), m_sel);
            chk("cyc_dout", int'(bus.dout), int'(m_dout));
            chk("cyc_busy", int'(bus.busy), int'(m_pend));
            chk("cyc_din_ready", int'(bus.din_ready), int'(!m_pend));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_word(input logic [WIDTH-1:0] d);
        bit ok = 1'b0;
        bus.din       = d;
        bus.din_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (bus.din_ready) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        bus.din_valid = 1'b0;
        chk("accept_timeout", int'(ok), 1);
    endtask

    task automatic wait_valid(output int s, output int lat);
        s   = -1;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.dout_valid != '0) begin
                s = int'(bus.sel);
                break;
            end
            tick();
            lat++;
        end
        if (s < 0) chk("valid_timeout", 0, 1);
    endtask

    task automatic finish_xfer();
        bus.dout_ready = '1;
        for (int i = 0; i < 40 && bus.busy; i++) tick();
        chk("finish_busy", int'(bus.busy), 0);
    endtask

    int s, lat;
    int rot_exp [5] = '{0, 1, 2, 3, 0};
    int msk_exp [3] = '{1, 3, 1};

    initial begin
        bus.din = '0; bus.din_valid = 1'b0; bus.en_mask = '1; bus.dout_ready = '1;
        rst = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        chk("rst_dout_valid", int'(bus.dout_valid), 0);
        chk("rst_sel", int'(bus.sel), 0);
        chk("rst_dout", int'(bus.dout), 0);
        chk("rst_busy", int'(bus.busy), 0);
        rst = 1'b0;
        tick();
        chk("rst_din_ready", int'(bus.din_ready), 1);

        // Rotation over all outputs
        for (int i = 0; i < 5; i++) begin
            accept_word(8'hA1 + 8'(i));
            wait_valid(s, lat);
            chk("rot_sel", s, rot_exp[i]);
            chk("rot_latency", lat, 1);
            chk("rot_dout", int'(bus.dout), 'hA1 + i);
            finish_xfer();
        end

        // Masked rotation with wrap
        bus.en_mask = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            accept_word(8'h30 + 8'(i));
            wait_valid(s, lat);
            chk("mask_sel", s, msk_exp[i]);
            finish_xfer();
        end

        // Nothing enabled: word parks in arbitration
        bus.en_mask = 4'b0000;
        accept_word(8'h44);
        for (int i = 0; i < 4; i++) begin
            chk("park_din_ready", int'(bus.din_ready), 0);
            chk("park_dout_valid", int'(bus.dout_valid), 0);
            tick();
        end
        bus.en_mask = 4'b0100;
        wait_valid(s, lat);
        chk("park_sel", s, 2);
        chk("park_dout", int'(bus.dout), 'h44);
        finish_xfer();

        // Backpressure on output 0
        bus.en_mask = 4'b0001;
        bus.dout_ready = 4'b0000;
        accept_word(8'h77);
        wait_valid(s, lat);
        chk("bp_sel", s, 0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_dout_valid", int'(bus.dout_valid), 1);
            chk("bp_dout", int'(bus.dout), 'h77);
            tick();
        end
        chk("bp_busy_before", int'(bus.busy), 1);
        bus.dout_ready = 4'b0001;
        tick();
        chk("bp_busy_after", int'(bus.busy), 0);

        // Reset while holding a word in SEND
        bus.en_mask = 4'b1111;
        bus.dout_ready = 4'b0000;
        accept_word(8'h5C);
        wait_valid(s, lat);
        chk("mid_sel", s, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_dout_valid", int'(bus.dout_valid), 0);
        chk("mid_busy", int'(bus.busy), 0);
        bus.dout_ready = 4'b1111;
        accept_word(8'hC3);
        wait_valid(s, lat);
        chk("mid_next_sel", s, 0);
        finish_xfer();

        // Ready-aware selection from ptr=1
        bus.en_mask = 4'b1111;
        bus.dout_ready = 4'b1001;
        accept_word(8'h3D);
        wait_valid(s, lat);
`ifdef DEMUX_RR_SCHED_SKIP_EN
        chk("skip_sel", s, 3);
`else
        chk("skip_sel", s, 1);
`endif
        finish_xfer();

        // Random traffic, model-checked every cycle
        for (int i = 0; i < 3000; i++) begin
            bus.din_valid  = 1'($urandom_range(0, 1));
            bus.din        = WIDTH'($urandom);
            bus.en_mask    = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom);
            bus.dout_ready = 4'($urandom);
            rst            = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;
        bus.din_valid = 1'b0;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
